// File: rtl/pc_fetch_gen_pkg.sv
// Shared definitions for the fetch-stage PC generator and its cache request bus.
package pc_fetch_gen_pkg;

  // Bit of the exception tag that marks a misaligned fetch address.
  localparam int unsigned EXC_ADEL_BIT = 4;

  // Largest fetch group supported; it fixes the cnt field width of the bus.
  localparam int unsigned FETCH_W_MAX = 4;
  localparam int unsigned CNT_W_MAX   = $clog2(FETCH_W_MAX) + 1;

  // PC generator state: BOOT idles one cycle, RUN issues, HOLD_EXC parks after a bad address.
  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_HOLD_EXC = 2'd2
  } fetch_state_e;

  // PC-to-icache request payload, packed as {excepttype, cnt, req, addr}.
  typedef struct packed {
    logic [31:0]          excepttype;
    logic [CNT_W_MAX-1:0] cnt;
    logic                 req;
    logic [31:0]          addr;
  } pc_to_ic_t;

  localparam int unsigned PC_TO_IC_WD = $bits(pc_to_ic_t);

endpackage

// File: rtl/pc_fetch_gen.sv
// Fetch-group PC generator: issues aligned group requests to the icache, honours
// the PC-stage stall, applies flush/branch redirects, and tags misaligned fetches.
module pc_fetch_gen
  import pc_fetch_gen_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = 32'hbfc0_0000,
  parameter int unsigned FETCH_W   = 1,
  parameter int unsigned STALL_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     flush,
  input  logic [31:0]              new_pc,
  input  logic                     br_e,
  input  logic [31:0]              br_target,
  output logic                     ic_req,
  output logic [31:0]              ic_addr,
  output logic [$clog2(FETCH_W):0] ic_cnt,
  output logic [31:0]              ic_excepttype,
  input  logic                     ic_ready
);

  localparam int unsigned CNT_W = $clog2(FETCH_W) + 1;
  localparam int unsigned GRP_B = FETCH_W * 4;
  localparam int unsigned OFF_W = $clog2(GRP_B);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  seq_next;
  logic [OFF_W-1:0] grp_word;
  logic         misaligned;
  logic         req;

  // Only bit 0 of the stall bus concerns the PC stage.
  logic unused_stall;
  assign unused_stall = ^stall;

  // Group arithmetic: next group base and word index of pc within its group.
  assign seq_next   = (pc_q & ~32'(GRP_B - 1)) + 32'(GRP_B);
  assign grp_word   = pc_q[OFF_W-1:0] >> 2;
  assign misaligned = |pc_q[1:0];

  // Request payload is a direct view of the pc register.
  assign ic_req  = req;
  assign ic_addr = pc_q;
  assign ic_cnt  = CNT_W'(FETCH_W) - CNT_W'(grp_word);

  // Exception tag carries only the address-error bit.
  always_comb begin
    ic_excepttype               = '0;
    ic_excepttype[EXC_ADEL_BIT] = misaligned;
  end

  // State and pc registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state / next pc; redirects win in every state, flush over branch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req     = (state_q == ST_RUN) && !stall[0];

    if (flush) begin
      pc_d    = new_pc;
      state_d = ST_RUN;
    end else if (br_e) begin
      pc_d    = br_target;
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT: state_d = ST_RUN;
        ST_RUN: begin
          if (req && ic_ready) begin
            if (misaligned) state_d = ST_HOLD_EXC;
            else            pc_d    = seq_next;
          end
        end
        ST_HOLD_EXC: state_d = ST_HOLD_EXC;
        default:     state_d = ST_BOOT;
      endcase
    end
  end

endmodule

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised PC generator at the head of the fetch pipeline; it replaces the single-issue PC register. Produces aligned fetch-group requests to the instruction cache through a valid/ready handshake. It honours the PC-stage stall and applies flush/branch redirects, including those that arrive while the PC stage is stalled. It also detects misaligned fetch addresses and tags them with an address-error exception instead of accessing memory.

## Interface
- RESET_VEC, 32'hbfc0_0000, first fetch address after reset
- FETCH_W, 1, instructions per fetch group; legal values 1, 2, 4
- STALL_W, 6, width of the pipeline stall bus
- CNT_W, $clog2(FETCH_W)+1, derived width of ic_cnt (not overridable)

- clk  in  1  clock; single clock domain
- rst  in  1  synchronous active-high reset
- stall  in  STALL_W  stall bus; bit 0 holds the PC stage
- flush  in  1  exception/eret redirect, one-cycle pulse
- new_pc  in  32  flush target
- br_e  in  1  branch redirect from EX, one-cycle pulse
- br_target  in  32  branch target
- ic_req  out  1  fetch request valid
- ic_addr  out  32  fetch address (first instruction of group)
- ic_cnt  out  CNT_W  valid instructions from ic_addr to end of group, 1..FETCH_W
- ic_excepttype  out  32  exception tag for this request; bit EXC_ADEL_BIT = misaligned
- ic_ready  in  1  cache accepts the request this cycle

## Operation
- GRP = FETCH_W*4 bytes. seq_next = (pc & ~(GRP-1)) + GRP, modulo 2^32.
- ic_cnt = FETCH_W - pc[log2(GRP)-1:2]. When FETCH_W=1, ic_cnt=1.
- ic_addr = pc. ic_excepttype = 0 except bit EXC_ADEL_BIT = (pc[1:0] != 0).
- FSM states:
  - BOOT: one cycle after reset; ic_req=0; then go to RUN.
  - RUN: ic_req = !stall[0].
  - HOLD_EXC: ic_req=0.
- Redirect priority: flush > br_e > sequential.
- A redirect is taken in every state, including BOOT and while stall[0]=1:
  - pc <= target, and the state goes to RUN; from BOOT this replaces the normal BOOT→RUN step.
  - A pending unaccepted request is abandoned. The cache samples only on ic_req&&ic_ready.
  - No separate pending-redirect buffer exists; the pc register holds the target.
- Advance: in RUN with ic_req&&ic_ready and no redirect:
  - aligned pc: pc <= seq_next.
  - misaligned pc: pc holds and the state goes to HOLD_EXC.
- Hold: ic_req && !ic_ready → pc, ic_cnt and ic_excepttype are stable.
- stall[0]=1 in RUN: ic_req=0 and pc holds unless a redirect occurs.
- Redirect targets are not required to be aligned. A misaligned target is issued once with the exception tag.

## Timing
- Reset: pc=RESET_VEC, state=BOOT, ic_req=0, ic_cnt=FETCH_W - RESET_VEC offset, ic_excepttype=0.
- First request: ic_req=1 with ic_addr=RESET_VEC in the second cycle after rst deasserts.
- Redirect sampled in cycle t → ic_addr=target in cycle t+1, with ic_req=1 if stall[0]=0.
- Accept in cycle t → next group address presented in cycle t+1. Throughput is one group per cycle.
- Redirect and ic_ready in the same cycle: the current address is accepted and the redirect target follows. The group returned for that accepted address is killed downstream by the flush/branch logic, not here.
- rst mid-request overrides everything; an outstanding request is dropped.
- Wrap: seq_next from group 32'hffff_fff8 (FETCH_W=2) is 32'h0000_0000.

## Structure
- Shared package (extend lib/defines.vh):
  - EXC_ADEL_BIT = 4
  - FSM state encoding (BOOT, RUN, HOLD_EXC)
  - PC_TO_IC_WD updated for the {excepttype, cnt, req, addr} bus
- Single module; no sub-module. Group-offset arithmetic stays inline.

## Test plan
- Reset, FETCH_W=2, RESET_VEC=bfc0_0004, ic_ready=1 → addr bfc00004 cnt 1, then bfc00008 cnt 2, then bfc00010.
- ic_ready low for 3 cycles at bfc00008 → addr, cnt and exception tag stable, pc not advanced; ready high → bfc00010 next cycle.
- stall[0]=1 for 4 cycles with a br_e pulse (target 8000_0100) in cycle 2 → ic_req=0 throughout; first request after stall is 8000_0100.
- flush (new_pc bfc00380) and br_e (8000_0000) in the same cycle → next ic_addr=bfc00380.
- br_e to 8000_0102 → one request with excepttype bit4=1, then HOLD_EXC (ic_req=0); flush to bfc00380 → RUN at bfc00380.
- FETCH_W=4, flush to ffff_fff8 → cnt 2; after accept, addr 0000_0000 cnt 4.
